// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// word-address masking and the stall counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } dmem_state_e;

  localparam int STALL_CNT_WIDTH = 32;
  localparam int MAX_ADDR_WIDTH  = 64;

  // Clears the byte-offset bits so every access is word aligned.
  function automatic logic [MAX_ADDR_WIDTH-1:0] word_addr(input logic [MAX_ADDR_WIDTH-1:0] byte_addr);
    return {byte_addr[MAX_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side and backing-memory-side signals of the data-memory controller.
// slave: the controller's view; master: the CPU plus backing memory.
interface data_mem_ctrl_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr;
  logic                       cpu_data_mem_read;
  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr;
  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata;
  logic                       cpu_data_mem_write;
  logic [DATA_WIDTH-1:0]      data_mem_rdata;
  logic                       data_mem_hazard;
  logic                       mem_req;
  logic                       mem_we;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ready;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  cpu_data_mem_raddr, cpu_data_mem_read, cpu_data_mem_waddr,
    input  cpu_data_mem_wdata, cpu_data_mem_write, mem_ready, mem_rdata,
    output data_mem_rdata, data_mem_hazard, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_data_mem_raddr, cpu_data_mem_read, cpu_data_mem_waddr,
    output cpu_data_mem_wdata, cpu_data_mem_write, mem_ready, mem_rdata,
    input  data_mem_rdata, data_mem_hazard, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_ctrl_chk.sv
// Protocol checker for the data-memory controller boundary.
module data_mem_ctrl_chk #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic                       read,
  input logic                       write,
  input logic                       mem_req,
  input logic                       mem_ready,
  input logic                       mem_we,
  input logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  input logic [DATA_WIDTH-1:0]      mem_wdata
);
  // The CPU must never request a read and a write in the same cycle.
  a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n) !(read && write));

  // A backing request holds its attributes until the memory accepts it.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_ready) |=> (mem_req && $stable(mem_we) && $stable(mem_addr) && $stable(mem_wdata)));
endmodule

// File: rtl/dmem_wbuf.sv
// One-entry posted-write buffer with read-address match for forwarding.
// Addresses arrive already word aligned.
module dmem_wbuf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  hit
);
  logic                  valid_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;

  // Entry update: a push wins over a same-cycle pop so a write accepted at drain completion is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
    end else if (push) begin
      valid_r <= 1'b1;
      addr_r  <= push_addr;
      data_r  <= push_data;
    end else if (pop) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign addr  = addr_r;
  assign data  = data_r;
  assign hit   = valid_r && (addr_r == match_addr);
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: posts CPU writes through a one-entry buffer,
// forwards buffered data to matching reads, issues read misses to the
// backing memory and stalls the pipeline while work is outstanding.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  data_mem_ctrl_if.slave             bus,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);
  dmem_state_e                state_r;
  dmem_state_e                state_s;
  logic [DATA_ADDR_WIDTH-1:0] raddr_w_s;
  logic [DATA_ADDR_WIDTH-1:0] waddr_w_s;
  logic [DATA_ADDR_WIDTH-1:0] rd_addr_r;
  logic [DATA_WIDTH-1:0]      rd_q_r;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;
  logic                       wb_valid_s;
  logic [DATA_ADDR_WIDTH-1:0] wb_addr_s;
  logic [DATA_WIDTH-1:0]      wb_data_s;
  logic                       fwd_hit_s;
  logic                       drain_done_s;
  logic                       wr_accept_s;
  logic                       rd_req_s;
  logic                       rd_start_s;
  logic                       hazard_raw_s;
  logic [DATA_WIDTH-1:0]      rdata_s;

  assign raddr_w_s    = DATA_ADDR_WIDTH'(word_addr(MAX_ADDR_WIDTH'(bus.cpu_data_mem_raddr)));
  assign waddr_w_s    = DATA_ADDR_WIDTH'(word_addr(MAX_ADDR_WIDTH'(bus.cpu_data_mem_waddr)));
  assign drain_done_s = (state_r == ST_WR) && bus.mem_ready;
  assign wr_accept_s  = bus.cpu_data_mem_write && (!wb_valid_s || drain_done_s);
  // A simultaneous write takes priority; the read is dropped.
  assign rd_req_s     = bus.cpu_data_mem_read && !bus.cpu_data_mem_write;

  dmem_wbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DATA_ADDR_WIDTH)
  ) u_wbuf (
    .clk        (cpu_clk),
    .rst_n      (cpu_rst_n),
    .push       (wr_accept_s),
    .pop        (drain_done_s),
    .push_addr  (waddr_w_s),
    .push_data  (bus.cpu_data_mem_wdata),
    .match_addr (raddr_w_s),
    .valid      (wb_valid_s),
    .addr       (wb_addr_s),
    .data       (wb_data_s),
    .hit        (fwd_hit_s)
  );

  // Hazard, CPU read data and next-state selection.
  always_comb begin
    state_s      = state_r;
    hazard_raw_s = 1'b0;
    rdata_s      = '0;
    rd_start_s   = 1'b0;

    if (bus.cpu_data_mem_write) begin
      hazard_raw_s = !wr_accept_s;
    end else if (bus.cpu_data_mem_read) begin
      if (state_r == ST_RESP) begin
        rdata_s = rd_q_r;
      end else if (fwd_hit_s) begin
        rdata_s = wb_data_s;
      end else begin
        hazard_raw_s = 1'b1;
      end
    end else begin
      hazard_raw_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (wr_accept_s) begin
          state_s = ST_WR;
        end else if (rd_req_s && !fwd_hit_s && !wb_valid_s) begin
          state_s    = ST_RD;
          rd_start_s = 1'b1;
        end else if (wb_valid_s) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (drain_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_RD: begin
        if (bus.mem_ready) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, captured read address/data and stall counter.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r     <= ST_IDLE;
      rd_addr_r   <= '0;
      rd_q_r      <= '0;
      stall_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if (rd_start_s) begin
        rd_addr_r <= raddr_w_s;
      end
      if ((state_r == ST_RD) && bus.mem_ready) begin
        rd_q_r <= bus.mem_rdata;
      end
      if (hazard_raw_s) begin
        stall_cnt_r <= stall_cnt_r + STALL_CNT_WIDTH'(1);
      end
    end
  end

  // Backing-memory request decoded purely from registered state so it drops with reset.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_r)
      ST_WR: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_addr_s;
        bus.mem_wdata = wb_data_s;
      end
      ST_RD: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = rd_addr_r;
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
  end

  // CPU-facing outputs are forced low while reset is asserted.
  assign bus.data_mem_hazard = hazard_raw_s & cpu_rst_n;
  assign bus.data_mem_rdata  = cpu_rst_n ? rdata_s : '0;
  assign stall_cnt           = stall_cnt_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: table-driven single transactions
// plus hand-written forwarding, ordering, back-to-back and reset sequences.
module tb_data_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) bus ();

  data_mem_ctrl #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  data_mem_ctrl_chk #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .read      (bus.cpu_data_mem_read),
    .write     (bus.cpu_data_mem_write),
    .mem_req   (bus.mem_req),
    .mem_ready (bus.mem_ready),
    .mem_we    (bus.mem_we),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata)
  );

  int checks   = 0;
  int failures = 0;

  // Backing memory model: ready in the lat-th cycle of each request.
  int          lat = 1;
  int          req_cyc;
  logic [31:0] rd_val = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_cyc <= 0;
    else if (bus.mem_req && bus.mem_ready) req_cyc <= 0;
    else if (bus.mem_req) req_cyc <= req_cyc + 1;
  end

  assign bus.mem_ready = bus.mem_req && (req_cyc == lat - 1);
  assign bus.mem_rdata = bus.mem_ready ? rd_val : 32'h0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [31:0] rd_exp_q[$];
  int          exp_stall_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing-memory scoreboard: each completed transfer must match the next expected one.
  always @(negedge clk) begin
    mem_txn_t t;
    if (rst_n && bus.mem_req && bus.mem_ready) begin
      check("mem_txn_expected", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        t = mem_q.pop_front();
        check("mem_we", 32'(bus.mem_we), 32'(t.we));
        check("mem_addr", bus.mem_addr, t.addr);
        if (t.we) check("mem_wdata", bus.mem_wdata, t.wdata);
      end
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
    int n = 0;
    bit done = 1'b0;
    mem_q.push_back('{we: 1'b1, addr: {a[31:2], 2'b00}, wdata: d});
    bus.cpu_data_mem_waddr = a;
    bus.cpu_data_mem_wdata = d;
    bus.cpu_data_mem_write = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.data_mem_hazard) n++;
      else done = 1'b1;
    end
    check("wr_accepted", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_data_mem_write = 1'b0;
    stalls = n;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input bit backing,
                          output int stalls);
    int n = 0;
    bit done = 1'b0;
    logic [31:0] e;
    if (backing) mem_q.push_back('{we: 1'b0, addr: {a[31:2], 2'b00}, wdata: 32'h0});
    rd_exp_q.push_back(exp);
    bus.cpu_data_mem_raddr = a;
    bus.cpu_data_mem_read  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.data_mem_hazard) begin
        n++;
      end else begin
        done = 1'b1;
        e = rd_exp_q.pop_front();
        check("rd_data", bus.data_mem_rdata, e);
      end
    end
    check("rd_completed", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_data_mem_read = 1'b0;
    stalls = n;
  endtask

  // Waits for two consecutive cycles without a backing request, then realigns after a rising edge.
  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 100 && q < 2; i++) begin
      @(negedge clk);
      if (!bus.mem_req) q++;
      else q = 0;
    end
    check("bus_quiet", 32'(q >= 2), 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          exp_stall;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s;
    int s2;

    // Writes never stall on an empty buffer; a miss stalls N+1 cycles.
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0};
    vecs[1] = '{1'b0, 32'h0000_0040, 32'hCAFE_0001, 3, 4};
    vecs[2] = '{1'b0, 32'h0000_0107, 32'h0BAD_F00D, 1, 2};
    vecs[3] = '{1'b1, 32'h0000_0203, 32'hA5A5_5A5A, 2, 0};
    vecs[4] = '{1'b0, 32'h0000_0300, 32'h1357_9BDF, 5, 6};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_0000, 4, 0};
    vecs[6] = '{1'b0, 32'h0000_0200, 32'h2468_ACE0, 2, 3};

    bus.cpu_data_mem_raddr = 32'h0;
    bus.cpu_data_mem_read  = 1'b0;
    bus.cpu_data_mem_waddr = 32'h0;
    bus.cpu_data_mem_wdata = 32'h0;
    bus.cpu_data_mem_write = 1'b0;

    #12;
    check("rst_hazard", 32'(bus.data_mem_hazard), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", bus.data_mem_rdata, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      lat = vecs[i].lat;
      if (vecs[i].is_wr) begin
        cpu_write(vecs[i].addr, vecs[i].data, s);
        check("vec_wr_stall", 32'(s), 32'(vecs[i].exp_stall));
        @(negedge clk);
        check("vec_drain_req", 32'(bus.mem_req), 32'd1);
        check("vec_drain_we", 32'(bus.mem_we), 32'd1);
      end else begin
        rd_val = vecs[i].data;
        cpu_read(vecs[i].addr, vecs[i].data, 1'b1, s);
        check("vec_rd_stall", 32'(s), 32'(vecs[i].exp_stall));
      end
      exp_stall_total += vecs[i].exp_stall;
      wait_quiet();
    end
    check("vec_stall_cnt", stall_cnt, 32'(exp_stall_total));

    // Forward hit while the drain is still waiting on the memory.
    lat = 4;
    cpu_write(32'h20, 32'h1234_5678, s);
    check("fwd_wr_stall", 32'(s), 32'd0);
    cpu_read(32'h22, 32'h1234_5678, 1'b0, s);
    check("fwd_rd_stall", 32'(s), 32'd0);
    wait_quiet();

    // Read miss behind a buffered write: 2 drain + 1 idle + 2 read cycles.
    lat = 2;
    rd_val = 32'h6060_6060;
    cpu_write(32'h50, 32'h5555_AAAA, s);
    cpu_read(32'h60, 32'h6060_6060, 1'b1, s);
    check("order_rd_stall", 32'(s), 32'd5);
    exp_stall_total += 5;
    wait_quiet();

    // Back-to-back writes: the second waits for the first drain's ready cycle.
    lat = 3;
    cpu_write(32'h70, 32'h7070_7070, s);
    cpu_write(32'h74, 32'h7474_7474, s2);
    check("b2b_first_stall", 32'(s), 32'd0);
    check("b2b_second_stall", 32'(s2), 32'd2);
    exp_stall_total += 2;
    wait_quiet();
    check("seq_stall_cnt", stall_cnt, 32'(exp_stall_total));

    // Reset during an outstanding read.
    lat = 10;
    bus.cpu_data_mem_raddr = 32'h80;
    bus.cpu_data_mem_read  = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_pending_req", 32'(bus.mem_req), 32'd1);
    check("rd_pending_addr", bus.mem_addr, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_hazard", 32'(bus.data_mem_hazard), 32'd0);
    check("midrst_stall_cnt", stall_cnt, 32'h0);
    exp_stall_total = 0;
    @(negedge clk);
    bus.cpu_data_mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_idle", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    lat = 2;
    rd_val = 32'h8484_8484;
    cpu_read(32'h84, 32'h8484_8484, 1'b1, s);
    check("postrst_rd_stall", 32'(s), 32'd3);
    exp_stall_total += 3;
    check("postrst_stall_cnt", stall_cnt, 32'(exp_stall_total));
    wait_quiet();

    // Reset with a buffered write still draining: the write is discarded.
    lat = 10;
    cpu_write(32'h90, 32'h9090_9090, s);
    @(negedge clk);
    check("discard_drain_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    mem_q.delete();
    exp_stall_total = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("discard_no_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    lat = 1;
    rd_val = 32'hA0A0_0BB0;
    cpu_read(32'hA0, 32'hA0A0_0BB0, 1'b1, s);
    check("final_rd_stall", 32'(s), 32'd2);
    exp_stall_total += 2;
    wait_quiet();

    check("final_stall_cnt", stall_cnt, 32'(exp_stall_total));
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule
